// File: rtl/chronos.sv
// Shared Chronos task-queue and undo-log types used by application task units.
package chronos;

    localparam int unsigned TS_WIDTH            = 32;
    localparam int unsigned OBJECT_WIDTH        = 32;
    localparam int unsigned TTYPE_WIDTH         = 4;
    localparam int unsigned ARGS_WIDTH          = 64;
    localparam int unsigned UNDO_LOG_ADDR_WIDTH = 32;
    localparam int unsigned UNDO_LOG_DATA_WIDTH = 32;

    typedef struct packed {
        logic [ARGS_WIDTH-1:0]   args;
        logic [TTYPE_WIDTH-1:0]  ttype;
        logic [OBJECT_WIDTH-1:0] object;
        logic [TS_WIDTH-1:0]     ts;
    } task_t;

    localparam int unsigned TQ_WIDTH = $bits(task_t);

    typedef struct packed {
        logic [UNDO_LOG_ADDR_WIDTH-1:0] addr;
        logic [UNDO_LOG_DATA_WIDTH-1:0] data;
    } undo_log_entry_t;

endpackage

// File: rtl/color_split_pkg.sv
// Colour-split application constants: task type IDs, RECEIVE unit states, header layout.
package color_split_pkg;

    localparam logic [chronos::TTYPE_WIDTH-1:0] TaskEnqueuer = 4'd0;
    localparam logic [chronos::TTYPE_WIDTH-1:0] TaskCalc     = 4'd1;
    localparam logic [chronos::TTYPE_WIDTH-1:0] TaskColor    = 4'd2;
    localparam logic [chronos::TTYPE_WIDTH-1:0] TaskReceive  = 4'd3;

    localparam logic [7:0] HdrArLen        = 8'd9;
    localparam logic [3:0] HdrEnqLimitWord = 4'd9;

    typedef enum logic [3:0] {
        StNextTask,
        StReadHeaders,
        StWaitHeaders,
        StDispatchTask,
        StReadScratch,
        StWaitScratch,
        StEval,
        StWriteCnt,
        StWaitBCnt,
        StWriteBm,
        StWaitBBm,
        StEnqColor,
        StFinishTask
    } color_mw_state_t;

    // Byte distance between consecutive vertex records: counter word plus bitmap.
    function automatic logic [31:0] record_stride(int unsigned words);
        return 32'(4 * (1 + words));
    endfunction

endpackage

// File: rtl/axi_single_write.sv
// One-beat AXI write sequencer: AW and W complete independently, B may arrive early.
module axi_single_write #(
    parameter bit WaitBresp = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic        wait_b,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    input  logic        bvalid,
    output logic        done,
    output logic        b_ok
);

    logic aw_done_q, w_done_q, b_seen_q;
    logic aw_fire, w_fire;

    always_comb begin
        awvalid = active & ~aw_done_q;
        wvalid  = active & ~w_done_q;
        awaddr  = addr;
        wdata   = data;
        aw_fire = awvalid & awready;
        w_fire  = wvalid & wready;
        done    = active & (aw_done_q | aw_fire) & (w_done_q | w_fire);
        b_ok    = bvalid | b_seen_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_seen_q  <= 1'b0;
        end else begin
            if (done) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_fire) aw_done_q <= 1'b1;
                if (w_fire)  w_done_q  <= 1'b1;
            end
            // A response landing while still in the write phase is held for the wait phase.
            if (wait_b && b_ok) begin
                b_seen_q <= 1'b0;
            end else if (WaitBresp && active && bvalid) begin
                b_seen_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_receive_mw.sv
// Graph-colouring RECEIVE task unit with a multi-word forbidden-colour bitmap.
module color_receive_mw
    import chronos::*;
    import color_split_pkg::*;
#(
    parameter int unsigned BITMAP_WORDS     = 4,
    parameter bit          WAIT_BRESP       = 1'b1,
    parameter int unsigned HDR_SCRATCH_WORD = 7
) (
    input  logic                                           ap_clk,
    input  logic                                           ap_rst_n,
    input  logic                                           ap_start,
    output logic                                           ap_done,
    output logic                                           ap_idle,
    output logic                                           ap_ready,
    input  logic [TQ_WIDTH-1:0]                            task_in,
    output logic [TQ_WIDTH-1:0]                            task_out_V_TDATA,
    output logic                                           task_out_V_TVALID,
    input  logic                                           task_out_V_TREADY,
    output logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] undo_log_entry,
    output logic                                           undo_log_entry_ap_vld,
    input  logic                                           undo_log_entry_ap_rdy,
    output logic                                           m_axi_l1_V_ARVALID,
    input  logic                                           m_axi_l1_V_ARREADY,
    output logic [31:0]                                    m_axi_l1_V_ARADDR,
    output logic [7:0]                                     m_axi_l1_V_ARLEN,
    output logic [2:0]                                     m_axi_l1_V_ARSIZE,
    input  logic                                           m_axi_l1_V_RVALID,
    output logic                                           m_axi_l1_V_RREADY,
    input  logic [31:0]                                    m_axi_l1_V_RDATA,
    input  logic                                           m_axi_l1_V_RLAST,
    input  logic [0:0]                                     m_axi_l1_V_RID,
    input  logic [1:0]                                     m_axi_l1_V_RRESP,
    output logic                                           m_axi_l1_V_AWVALID,
    input  logic                                           m_axi_l1_V_AWREADY,
    output logic [31:0]                                    m_axi_l1_V_AWADDR,
    output logic [7:0]                                     m_axi_l1_V_AWLEN,
    output logic [2:0]                                     m_axi_l1_V_AWSIZE,
    output logic                                           m_axi_l1_V_WVALID,
    input  logic                                           m_axi_l1_V_WREADY,
    output logic [31:0]                                    m_axi_l1_V_WDATA,
    output logic [3:0]                                     m_axi_l1_V_WSTRB,
    output logic                                           m_axi_l1_V_WLAST,
    input  logic                                           m_axi_l1_V_BVALID,
    output logic                                           m_axi_l1_V_BREADY,
    input  logic [1:0]                                     m_axi_l1_V_BRESP,
    input  logic [0:0]                                     m_axi_l1_V_BID,
    output logic [31:0]                                    ap_state
);

    localparam logic [31:0] Stride    = record_stride(BITMAP_WORDS);
    localparam logic [31:0] NumColors = 32'(32 * BITMAP_WORDS);

    color_mw_state_t state_q, state_d;
    logic            initialized_q;
    logic [3:0]      word_id_q;
    logic [31:0]     base_scratch_q;
    logic [6:0]      enq_limit_q;
    task_t           cur_task_q;
    logic [31:0]     join_counter_q;
    logic [31:0]     sel_word_q;

    logic [31:0] color, rec_base, bm_addr, bm_word_id;
    logic [4:0]  bit_idx;
    logic        in_range, need_bm, r_fire;
    logic        wr_active, wr_wait_b, wr_done, wr_b_ok;
    logic [31:0] wr_addr, wr_data;
    color_mw_state_t enq_next, after_cnt;
    task_t       enq_task;

    always_comb begin
        color      = cur_task_q.args[31:0];
        bit_idx    = color[4:0];
        in_range   = color < NumColors;
        need_bm    = in_range & ~sel_word_q[bit_idx];
        rec_base   = base_scratch_q + cur_task_q.object * Stride;
        bm_addr    = rec_base + {3'b000, color[31:5], 2'b00} + 32'd4;
        bm_word_id = {5'd0, color[31:5]} + 32'd1;
        r_fire     = m_axi_l1_V_RVALID & m_axi_l1_V_RREADY;
    end

    always_comb begin
        m_axi_l1_V_ARVALID = 1'b0;
        m_axi_l1_V_ARADDR  = 32'd0;
        m_axi_l1_V_ARLEN   = 8'd0;
        if (state_q == StReadHeaders) begin
            m_axi_l1_V_ARVALID = 1'b1;
            m_axi_l1_V_ARLEN   = HdrArLen;
        end else if (state_q == StReadScratch) begin
            m_axi_l1_V_ARVALID = 1'b1;
            m_axi_l1_V_ARADDR  = rec_base;
            m_axi_l1_V_ARLEN   = 8'(BITMAP_WORDS);
        end
        m_axi_l1_V_ARSIZE = 3'b010;
        m_axi_l1_V_RREADY = (state_q == StWaitHeaders) || (state_q == StWaitScratch);

        wr_active = (state_q == StWriteCnt) || (state_q == StWriteBm);
        wr_wait_b = (state_q == StWaitBCnt) || (state_q == StWaitBBm);
        wr_addr   = (state_q == StWriteBm) ? bm_addr : rec_base;
        wr_data   = (state_q == StWriteBm) ? (sel_word_q | (32'd1 << bit_idx))
                                           : (join_counter_q - 32'd1);
        m_axi_l1_V_AWLEN  = 8'd0;
        m_axi_l1_V_AWSIZE = 3'b010;
        m_axi_l1_V_WSTRB  = 4'hF;
        m_axi_l1_V_WLAST  = 1'b1;
        m_axi_l1_V_BREADY = 1'b1;

        enq_task          = '0;
        enq_task.ttype    = TaskColor;
        enq_task.object   = cur_task_q.object;
        enq_task.ts       = cur_task_q.ts;
        task_out_V_TDATA  = enq_task;
        task_out_V_TVALID = (state_q == StEnqColor);

        undo_log_entry        = '0;
        undo_log_entry_ap_vld = 1'b0;
        ap_idle  = (state_q == StNextTask);
        ap_ready = (state_q == StNextTask);
        ap_done  = (state_q == StFinishTask);
        ap_state = {28'd0, state_q};
    end

    always_comb begin
        enq_next  = (join_counter_q == 32'd1) ? StEnqColor : StFinishTask;
        after_cnt = need_bm ? StWriteBm : enq_next;
        state_d   = state_q;
        unique case (state_q)
            StNextTask:     if (ap_start) state_d = initialized_q ? StDispatchTask : StReadHeaders;
            StReadHeaders:  if (m_axi_l1_V_ARREADY) state_d = StWaitHeaders;
            StWaitHeaders:  if (r_fire && m_axi_l1_V_RLAST) state_d = StDispatchTask;
            StDispatchTask: state_d = (cur_task_q.ttype == TaskReceive) ? StReadScratch
                                                                         : StFinishTask;
            StReadScratch:  if (m_axi_l1_V_ARREADY) state_d = StWaitScratch;
            StWaitScratch:  if (r_fire && m_axi_l1_V_RLAST) state_d = StEval;
            // A zero counter means a spurious RECEIVE; drop it without touching memory.
            StEval:         state_d = (join_counter_q == 32'd0) ? StFinishTask : StWriteCnt;
            StWriteCnt:     if (wr_done) state_d = WAIT_BRESP ? StWaitBCnt : after_cnt;
            StWaitBCnt:     if (wr_b_ok) state_d = after_cnt;
            StWriteBm:      if (wr_done) state_d = WAIT_BRESP ? StWaitBBm : enq_next;
            StWaitBBm:      if (wr_b_ok) state_d = enq_next;
            StEnqColor:     if (task_out_V_TREADY) state_d = StFinishTask;
            StFinishTask:   state_d = StNextTask;
            default:        state_d = StNextTask;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q        <= StNextTask;
            initialized_q  <= 1'b0;
            word_id_q      <= 4'd0;
            base_scratch_q <= 32'd0;
            enq_limit_q    <= 7'd0;
            cur_task_q     <= '0;
            join_counter_q <= 32'd0;
            sel_word_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StNextTask && ap_start) cur_task_q <= task_t'(task_in);
            if (state_q == StDispatchTask) initialized_q <= 1'b1;
            if (m_axi_l1_V_ARVALID) begin
                word_id_q <= 4'd0;
            end else if (r_fire) begin
                word_id_q <= word_id_q + 4'd1;
            end
            if (r_fire && state_q == StWaitHeaders) begin
                if (word_id_q == 4'(HDR_SCRATCH_WORD)) base_scratch_q <= {m_axi_l1_V_RDATA[29:0], 2'b00};
                if (word_id_q == HdrEnqLimitWord) enq_limit_q <= m_axi_l1_V_RDATA[6:0];
            end
            if (r_fire && state_q == StWaitScratch) begin
                if (word_id_q == 4'd0) begin
                    join_counter_q <= m_axi_l1_V_RDATA;
                end else if ({28'd0, word_id_q} == bm_word_id) begin
                    sel_word_q <= m_axi_l1_V_RDATA;
                end
            end
        end
    end

    axi_single_write #(
        .WaitBresp(WAIT_BRESP)
    ) u_writer (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .active (wr_active),
        .wait_b (wr_wait_b),
        .addr   (wr_addr),
        .data   (wr_data),
        .awvalid(m_axi_l1_V_AWVALID),
        .awready(m_axi_l1_V_AWREADY),
        .awaddr (m_axi_l1_V_AWADDR),
        .wvalid (m_axi_l1_V_WVALID),
        .wready (m_axi_l1_V_WREADY),
        .wdata  (m_axi_l1_V_WDATA),
        .bvalid (m_axi_l1_V_BVALID),
        .done   (wr_done),
        .b_ok   (wr_b_ok)
    );

    logic unused_ok;
    assign unused_ok = ^{enq_limit_q, cur_task_q.args[63:32], m_axi_l1_V_RID, m_axi_l1_V_RRESP,
                         m_axi_l1_V_BRESP, m_axi_l1_V_BID, undo_log_entry_ap_rdy};

endmodule
